// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
//   GRANT_W     : width of a requester index (up to 8 requesters)
//   BYTE_W      : width of one transmitted byte
//   arb_state_e : arbiter sequencing states
package uart_arb_pkg;

    localparam int GRANT_W = 3;
    localparam int BYTE_W  = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin priority search.
//   i_req   : request vector, one bit per requester
//   i_last  : index of the most recent winner
//   o_idx   : first requesting index after i_last (wrapping); i_last if none
//   o_found : at least one request is pending
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]    i_req,
    input  logic [GRANT_W-1:0] i_last,
    output logic [GRANT_W-1:0] o_idx,
    output logic               o_found
);

    int w_best;
    int w_dist;

    // Each requester's distance from the slot after i_last; smallest wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = i_last;
        w_best  = NREQ;
        w_dist  = 0;
        for (int p = 0; p < NREQ; p++) begin
            w_dist = (p + 2 * NREQ - 1 - int'(i_last)) % NREQ;
            if (i_req[p] && (w_dist < w_best)) begin
                w_best  = w_dist;
                o_found = 1'b1;
                o_idx   = GRANT_W'(p);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one 8N1 uart_tx between NREQ byte requesters with per-byte
// round-robin arbitration. The granted byte is held on o_tx_wdata for the
// whole frame because the transmitter samples it bit by bit.
//   i_clk, i_reset_n : clock, synchronous active-low reset
//   i_req_valid/data : per-requester byte offer (byte i at [8i+7:8i])
//   o_req_ack        : one-cycle pulse, requester's byte was latched
//   o_tx_wrreq/wdata : write request pulse and held byte to uart_tx
//   i_tx_ready       : uart_tx idle
//   o_busy           : arbiter not idle
//   o_grant_id       : last granted requester
//   o_err_timeout    : one-cycle pulse, tx_ready never fell after wrreq
//
// state     | meaning
// IDLE      | waiting for tx_ready and any request; grants on the same edge
// WAIT_BUSY | wrreq issued, waiting for tx_ready to fall (bounded)
// WAIT_DONE | frame in flight, waiting for tx_ready to rise
// GAP       | enforced idle clocks before the next grant
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int GAP_CYCLES   = 0,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic [NREQ-1:0]        i_req_valid,
    input  logic [BYTE_W*NREQ-1:0] i_req_data,
    output logic [NREQ-1:0]        o_req_ack,
    output logic                   o_tx_wrreq,
    output logic [BYTE_W-1:0]      o_tx_wdata,
    input  logic                   i_tx_ready,
    output logic                   o_busy,
    output logic [GRANT_W-1:0]     o_grant_id,
    output logic                   o_err_timeout
);

    localparam int GAP_W = 16;
    localparam int TO_W  = $clog2(BUSY_TIMEOUT + 1);
    // GAP holds for GAP_CYCLES edges, so load one less and leave at zero.
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(BUSY_TIMEOUT - 1);

    arb_state_e          r_state;
    logic [NREQ-1:0]     r_ack;
    logic                r_wrreq;
    logic [BYTE_W-1:0]   r_wdata;
    logic                r_busy;
    logic [GRANT_W-1:0]  r_grant;
    logic                r_err;
    logic [TO_W-1:0]     r_to_cnt;
    logic [GAP_W-1:0]    r_gap_cnt;

    arb_state_e          w_state;
    logic [NREQ-1:0]     w_ack;
    logic                w_wrreq;
    logic [BYTE_W-1:0]   w_wdata;
    logic                w_busy;
    logic [GRANT_W-1:0]  w_grant;
    logic                w_err;
    logic [TO_W-1:0]     w_to_cnt;
    logic [GAP_W-1:0]    w_gap_cnt;

    logic [GRANT_W-1:0]  w_pick;
    logic                w_found;
    logic [BYTE_W-1:0]   w_sel_byte;
    logic [NREQ-1:0]     w_sel_onehot;

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .i_req   (i_req_valid),
        .i_last  (r_grant),
        .o_idx   (w_pick),
        .o_found (w_found)
    );

    always_comb begin
        w_sel_byte   = '0;
        w_sel_onehot = '0;
        for (int p = 0; p < NREQ; p++) begin
            if (GRANT_W'(p) == w_pick) begin
                w_sel_byte      = i_req_data[p*BYTE_W +: BYTE_W];
                w_sel_onehot[p] = 1'b1;
            end
        end
    end

    always_comb begin
        w_state   = r_state;
        w_ack     = '0;
        w_wrreq   = 1'b0;
        w_wdata   = r_wdata;
        w_grant   = r_grant;
        w_err     = 1'b0;
        w_to_cnt  = r_to_cnt;
        w_gap_cnt = r_gap_cnt;

        unique case (r_state)
            IDLE: begin
                if (i_tx_ready && w_found) begin
                    w_wdata  = w_sel_byte;
                    w_grant  = w_pick;
                    w_ack    = w_sel_onehot;
                    w_wrreq  = 1'b1;
                    w_to_cnt = '0;
                    w_state  = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (!i_tx_ready) begin
                    w_state = WAIT_DONE;
                end else if (r_to_cnt == TO_LAST) begin
                    // Transmitter never accepted the byte; it is dropped.
                    w_err   = 1'b1;
                    w_state = IDLE;
                end else begin
                    w_to_cnt = r_to_cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (i_tx_ready) begin
                    if (GAP_CYCLES == 0) begin
                        w_state = IDLE;
                    end else begin
                        w_gap_cnt = GAP_LOAD;
                        w_state   = GAP;
                    end
                end
            end
            GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state = IDLE;
                end else begin
                    w_gap_cnt = r_gap_cnt - 1'b1;
                end
            end
            default: w_state = IDLE;
        endcase

        w_busy = (w_state != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state   <= IDLE;
            r_ack     <= '0;
            r_wrreq   <= 1'b0;
            r_wdata   <= '0;
            r_busy    <= 1'b0;
            r_grant   <= GRANT_W'(NREQ - 1);
            r_err     <= 1'b0;
            r_to_cnt  <= '0;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state;
            r_ack     <= w_ack;
            r_wrreq   <= w_wrreq;
            r_wdata   <= w_wdata;
            r_busy    <= w_busy;
            r_grant   <= w_grant;
            r_err     <= w_err;
            r_to_cnt  <= w_to_cnt;
            r_gap_cnt <= w_gap_cnt;
        end
    end

    assign o_req_ack     = r_ack;
    assign o_tx_wrreq    = r_wrreq;
    assign o_tx_wdata    = r_wdata;
    assign o_busy        = r_busy;
    assign o_grant_id    = r_grant;
    assign o_err_timeout = r_err;

endmodule
